// File: rtl/cpu_store_checker_if.sv
// Expected-store load channel plus the cpu store bus observed by cpu_store_checker.
interface cpu_store_checker_if #(
    parameter int N = 32
) ();
    logic         exp_valid;
    logic         exp_ready;
    logic [N-1:0] exp_addr;
    logic [N-1:0] exp_data;
    logic [N-1:0] pc;
    logic         memwrite;
    logic [N-1:0] aluout;
    logic [N-1:0] writedata;

    modport master (
        output exp_valid, exp_addr, exp_data, pc, memwrite, aluout, writedata,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_addr, exp_data, pc, memwrite, aluout, writedata,
        output exp_ready
    );
endinterface

// File: rtl/cpu_store_checker.sv
// Run monitor for the single-cycle cpu: matches observed stores against a preloaded
// ordered list and issues a pass/fail verdict on program halt or run timeout.
module cpu_store_checker #(
    parameter int N           = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_store_checker_if.slave       bus,
    input  logic                     start,
    output logic                     done,
    output logic                     pass,
    output logic [2:0]               fail_code,
    output logic [N-1:0]             err_got,
    output logic [N-1:0]             err_exp,
    output logic [$clog2(DEPTH):0]   store_count,
    output logic [$clog2(TIMEOUT):0] cycle_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(HALT_CYCLES) + 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [PW-1:0] FIFO_FULL  = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_ENTRY  = PW'(1'b1);
    // Halt fires on the comparison that would take the stall count to HALT_CYCLES-1
    localparam logic [SW-1:0] STALL_LAST = SW'(HALT_CYCLES - 2);
    localparam logic [CW-1:0] CYCLE_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_ADDR    = 3'd1;
    localparam logic [2:0] CODE_DATA    = 3'd2;
    localparam logic [2:0] CODE_UNEXP   = 3'd3;
    localparam logic [2:0] CODE_MISSING = 3'd4;
    localparam logic [2:0] CODE_TIMEOUT = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  addr_mem_r [DEPTH];
    logic [N-1:0]  data_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, wr_ptr_s;
    logic [PW-1:0] rd_ptr_r, rd_ptr_s;
    logic [N-1:0]  pc_q_r;
    logic [SW-1:0] stall_r, stall_s;
    logic          done_r, done_s;
    logic          pass_r, pass_s;
    logic [2:0]    code_r, code_s;
    logic [N-1:0]  err_got_r, err_got_s;
    logic [N-1:0]  err_exp_r, err_exp_s;
    logic [PW-1:0] store_r, store_s;
    logic [CW-1:0] cycle_r, cycle_s;

    logic [PW-1:0] fill_s;
    logic          empty_s, full_s, push_s, pc_same_s;
    logic          match_s, sfail_s, halt_s, drained_s;
    logic [AW-1:0] head_idx_s, next_idx_s;
    logic [N-1:0]  head_addr_s, head_data_s, next_addr_s;

    // FIFO occupancy, head entry and the entry behind it
    always_comb begin
        fill_s      = wr_ptr_r - rd_ptr_r;
        empty_s     = (fill_s == {PW{1'b0}});
        full_s      = (fill_s == FIFO_FULL);
        head_idx_s  = rd_ptr_r[AW-1:0];
        next_idx_s  = head_idx_s + AW'(1'b1);
        head_addr_s = addr_mem_r[head_idx_s];
        head_data_s = data_mem_r[head_idx_s];
        next_addr_s = addr_mem_r[next_idx_s];
        pc_same_s   = (bus.pc == pc_q_r);
    end

    assign bus.exp_ready = (state_r == IDLE) && !full_s;
    assign push_s        = bus.exp_ready && bus.exp_valid;

    // Next state, pointer updates and verdict values
    always_comb begin
        state_s   = state_r;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        stall_s   = stall_r;
        done_s    = done_r;
        pass_s    = pass_r;
        code_s    = code_r;
        err_got_s = err_got_r;
        err_exp_s = err_exp_r;
        store_s   = store_r;
        cycle_s   = cycle_r;
        match_s   = 1'b0;
        sfail_s   = 1'b0;
        halt_s    = 1'b0;
        drained_s = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = {SW{1'b0}};
                if (push_s) begin
                    wr_ptr_s = wr_ptr_r + PW'(1'b1);
                end else begin
                    wr_ptr_s = wr_ptr_r;
                end
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (bus.memwrite) begin
                    if (empty_s) begin
                        sfail_s   = 1'b1;
                        code_s    = CODE_UNEXP;
                        err_got_s = bus.aluout;
                        err_exp_s = {N{1'b0}};
                    end else if (bus.aluout != head_addr_s) begin
                        sfail_s   = 1'b1;
                        code_s    = CODE_ADDR;
                        err_got_s = bus.aluout;
                        err_exp_s = head_addr_s;
                    end else if (bus.writedata != head_data_s) begin
                        sfail_s   = 1'b1;
                        code_s    = CODE_DATA;
                        err_got_s = bus.writedata;
                        err_exp_s = head_data_s;
                    end else begin
                        match_s  = 1'b1;
                        rd_ptr_s = rd_ptr_r + PW'(1'b1);
                        store_s  = store_r + PW'(1'b1);
                    end
                end else begin
                    match_s = 1'b0;
                end
                halt_s    = pc_same_s && (stall_r == STALL_LAST);
                // A store matched in the halt cycle is already gone when emptiness is judged
                drained_s = match_s ? (fill_s == ONE_ENTRY) : empty_s;
                if (sfail_s) begin
                    state_s = FAIL;
                    done_s  = 1'b1;
                end else if (halt_s) begin
                    done_s = 1'b1;
                    if (drained_s) begin
                        state_s = PASS;
                        pass_s  = 1'b1;
                    end else begin
                        state_s   = FAIL;
                        code_s    = CODE_MISSING;
                        err_got_s = {N{1'b0}};
                        err_exp_s = match_s ? next_addr_s : head_addr_s;
                    end
                end else if (cycle_r == CYCLE_LAST) begin
                    state_s   = FAIL;
                    done_s    = 1'b1;
                    code_s    = CODE_TIMEOUT;
                    err_got_s = {N{1'b0}};
                    err_exp_s = {N{1'b0}};
                end else begin
                    cycle_s = cycle_r + CW'(1'b1);
                    if (pc_same_s) begin
                        stall_s = stall_r + SW'(1'b1);
                    end else begin
                        stall_s = {SW{1'b0}};
                    end
                end
            end
            PASS, FAIL: begin
                if (start) begin
                    state_s   = IDLE;
                    wr_ptr_s  = {PW{1'b0}};
                    rd_ptr_s  = {PW{1'b0}};
                    stall_s   = {SW{1'b0}};
                    done_s    = 1'b0;
                    pass_s    = 1'b0;
                    code_s    = CODE_NONE;
                    err_got_s = {N{1'b0}};
                    err_exp_s = {N{1'b0}};
                    store_s   = {PW{1'b0}};
                    cycle_s   = {CW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pointers, stall tracking, counters and registered verdict outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            pc_q_r    <= {N{1'b0}};
            stall_r   <= {SW{1'b0}};
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            code_r    <= CODE_NONE;
            err_got_r <= {N{1'b0}};
            err_exp_r <= {N{1'b0}};
            store_r   <= {PW{1'b0}};
            cycle_r   <= {CW{1'b0}};
        end else begin
            wr_ptr_r  <= wr_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
            pc_q_r    <= bus.pc;
            stall_r   <= stall_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
            code_r    <= code_s;
            err_got_r <= err_got_s;
            err_exp_r <= err_exp_s;
            store_r   <= store_s;
            cycle_r   <= cycle_s;
        end
    end

    // Expected-store storage, written only on an accepted offer
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r[AW-1:0]] <= bus.exp_addr;
            data_mem_r[wr_ptr_r[AW-1:0]] <= bus.exp_data;
        end
    end

    assign done        = done_r;
    assign pass        = pass_r;
    assign fail_code   = code_r;
    assign err_got     = err_got_r;
    assign err_exp     = err_exp_r;
    assign store_count = store_r;
    assign cycle_count = cycle_r;
endmodule

// File: tb/tb_cpu_store_checker.sv
// Directed bench for cpu_store_checker with a queue-based reference model and literal pins.
module tb_cpu_store_checker;
    localparam int DEPTH = 16;
    localparam int HALT  = 4;
    localparam int TOUT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done, pass;
    logic [2:0]  fail_code;
    logic [31:0] err_got, err_exp;
    logic [4:0]  store_count;
    logic [4:0]  cycle_count;

    int n_vec  = 0;
    int n_miss = 0;

    cpu_store_checker_if #(.N(32)) bus ();

    cpu_store_checker #(.N(32), .DEPTH(DEPTH), .HALT_CYCLES(HALT), .TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .start(start),
        .done(done), .pass(pass), .fail_code(fail_code),
        .err_got(err_got), .err_exp(err_exp),
        .store_count(store_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // reference model state
    bit          m_run = 1'b0, m_done = 1'b0, m_pass = 1'b0;
    int          m_code = 0, m_stores = 0, m_cycles = 0;
    logic [31:0] m_got = 32'd0, m_exp = 32'd0;
    logic [31:0] qa[$], qd[$], pcs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_run && !m_done && (qa.size() < DEPTH);
    endfunction

    function automatic bit m_halted();
        int n = pcs.size();
        if (n < HALT) return 1'b0;
        for (int i = 1; i < HALT; i++)
            if (pcs[n-1-i] != pcs[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_clear();
        m_run = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_code = 0;
        m_got = 32'd0; m_exp = 32'd0; m_stores = 0; m_cycles = 0;
        qa.delete(); qd.delete(); pcs.delete();
    endtask

    task automatic m_verdict(input bit ok, input int code, input logic [31:0] g, input logic [31:0] e);
        m_run = 1'b0; m_done = 1'b1; m_pass = ok; m_code = code; m_got = g; m_exp = e;
    endtask

    task automatic model_step();
        bit v;
        if (reset) begin
            m_clear();
        end else if (!m_run && !m_done) begin
            if (bus.exp_valid && qa.size() < DEPTH) begin
                qa.push_back(bus.exp_addr);
                qd.push_back(bus.exp_data);
            end
            if (start) begin
                m_run = 1'b1;
                pcs.delete();
                pcs.push_back(bus.pc);
            end
        end else if (m_run) begin
            v = 1'b0;
            pcs.push_back(bus.pc);
            if (bus.memwrite) begin
                if (qa.size() == 0) begin
                    m_verdict(1'b0, 3, bus.aluout, 32'd0); v = 1'b1;
                end else if (bus.aluout != qa[0]) begin
                    m_verdict(1'b0, 1, bus.aluout, qa[0]); v = 1'b1;
                end else if (bus.writedata != qd[0]) begin
                    m_verdict(1'b0, 2, bus.writedata, qd[0]); v = 1'b1;
                end else begin
                    void'(qa.pop_front()); void'(qd.pop_front()); m_stores++;
                end
            end
            if (!v && m_halted()) begin
                if (qa.size() == 0) m_verdict(1'b1, 0, 32'd0, 32'd0);
                else m_verdict(1'b0, 4, 32'd0, qa[0]);
                v = 1'b1;
            end
            if (!v && m_cycles == TOUT - 1) begin
                m_verdict(1'b0, 5, 32'd0, 32'd0); v = 1'b1;
            end
            if (!v) m_cycles++;
        end else if (start) begin
            m_clear();
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        check("exp_ready", 32'(bus.exp_ready), 32'(m_ready()));
        check("done", 32'(done), 32'(m_done));
        check("pass", 32'(pass), 32'(m_pass));
        check("fail_code", 32'(fail_code), 32'(m_code));
        check("err_got", err_got, m_got);
        check("err_exp", err_exp, m_exp);
        check("store_count", 32'(store_count), 32'(m_stores));
        check("cycle_count", 32'(cycle_count), 32'(m_cycles));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] p, input bit mw, input logic [31:0] a, input logic [31:0] d);
        bus.pc = p; bus.memwrite = mw; bus.aluout = a; bus.writedata = d;
        tick();
        bus.memwrite = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        bus.exp_valid = 1'b1; bus.exp_addr = a; bus.exp_data = d;
        tick();
        bus.exp_valid = 1'b0;
    endtask

    task automatic go(input logic [31:0] p);
        bus.pc = p; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0;
        bus.exp_valid = 1'b0; bus.exp_addr = 32'd0; bus.exp_data = 32'd0;
        bus.pc = 32'd0; bus.memwrite = 1'b0; bus.aluout = 32'd0; bus.writedata = 32'd0;
        #12 reset = 1'b0;
        tick();
        check("rst_ready", 32'(bus.exp_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);

        // two matching stores then halt -> pass
        load(32'h10, 32'd5); load(32'h14, 32'd7);
        go(32'h30);
        step(32'h34, 1'b1, 32'h10, 32'd5);
        step(32'h38, 1'b1, 32'h14, 32'd7);
        for (int i = 0; i < 3; i++) step(32'h40, 1'b0, 32'd0, 32'd0);
        check("halt_early_done", 32'(done), 32'd0);
        step(32'h40, 1'b0, 32'd0, 32'd0);
        check("pass_done", 32'(done), 32'd1);
        check("pass_pass", 32'(pass), 32'd1);
        check("pass_stores", 32'(store_count), 32'd2);
        check("pass_code", 32'(fail_code), 32'd0);
        go(32'h50);
        check("restart_stores", 32'(store_count), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        check("restart_ready", 32'(bus.exp_ready), 32'd1);

        // data mismatch
        load(32'h10, 32'd5); go(32'h100);
        step(32'h104, 1'b1, 32'h10, 32'd6);
        check("data_code", 32'(fail_code), 32'd2);
        check("data_got", err_got, 32'd6);
        check("data_exp", err_exp, 32'd5);
        check("data_stores", 32'(store_count), 32'd0);
        go(32'h0);

        // address mismatch wins over data mismatch
        load(32'h10, 32'd5); go(32'h110);
        step(32'h114, 1'b1, 32'h20, 32'd6);
        check("addr_code", 32'(fail_code), 32'd1);
        check("addr_got", err_got, 32'h20);
        check("addr_exp", err_exp, 32'h10);
        go(32'h0);

        // unexpected store into empty list
        go(32'h120);
        step(32'h124, 1'b1, 32'h08, 32'd1);
        check("unexp_code", 32'(fail_code), 32'd3);
        check("unexp_got", err_got, 32'h08);
        go(32'h0);

        // missing store at halt
        load(32'h10, 32'd5); load(32'h24, 32'd9); go(32'h200);
        step(32'h204, 1'b1, 32'h10, 32'd5);
        for (int i = 0; i < 4; i++) step(32'h208, 1'b0, 32'd0, 32'd0);
        check("miss_code", 32'(fail_code), 32'd4);
        check("miss_exp", err_exp, 32'h24);
        check("miss_stores", 32'(store_count), 32'd1);
        go(32'h0);

        // matching store in the halt cycle is popped first -> pass
        load(32'h30, 32'd3); go(32'h300);
        step(32'h300, 1'b0, 32'd0, 32'd0);
        step(32'h300, 1'b0, 32'd0, 32'd0);
        step(32'h300, 1'b1, 32'h30, 32'd3);
        check("halt_pop_pass", 32'(pass), 32'd1);
        check("halt_pop_stores", 32'(store_count), 32'd1);
        go(32'h0);

        // timeout with a running pc
        go(32'h400);
        k = 0;
        while (!done && k < 40) begin
            step(32'h404 + 32'(4 * k), 1'b0, 32'd0, 32'd0);
            k++;
        end
        check("timeout_done", 32'(done), 32'd1);
        check("timeout_code", 32'(fail_code), 32'd5);
        check("timeout_cycles", 32'(cycle_count), 32'd15);
        go(32'h0);

        // offer 17 entries to a 16-deep list
        for (int i = 0; i < 17; i++) load(32'h1000 + 32'(4 * i), 32'(i));
        check("full_ready", 32'(bus.exp_ready), 32'd0);
        go(32'h500);
        step(32'h504, 1'b0, 32'd0, 32'd0);
        step(32'h508, 1'b0, 32'd0, 32'd0);
        check("run_ready", 32'(bus.exp_ready), 32'd0);
        reset = 1'b1;
        #2;
        check("abort_ready", 32'(bus.exp_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cycles", 32'(cycle_count), 32'd0);
        #3 reset = 1'b0;
        tick();

        // list contents discarded by reset: halt alone passes
        go(32'h600);
        for (int i = 0; i < 3; i++) step(32'h600, 1'b0, 32'd0, 32'd0);
        check("post_reset_pass", 32'(pass), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
